mux2_pipe: RTL and testbench

- Registered 2:1 datapath selector with a valid/ready stream interface.
- Each accepted beat captures in1 when sel=0, or in2 when sel=1, and presents it on out one cycle later.
- A 2-entry skid stage gives full throughput under backpressure with a purely registered in_ready.
- Generic building block for datapath operand/writeback selection.

---
 rtl/mux2_pipe.sv | 82 ++++++++
 tb/tb_mux2_pipe.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux2_pipe.sv
// Registered 2:1 selector with a valid/ready stream interface.
// A main output register plus one skid register sustain one beat per cycle under backpressure.
module mux2_pipe #(
    parameter int unsigned dataCount = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sel,
    input  logic [dataCount-1:0] in1,
    input  logic [dataCount-1:0] in2,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [dataCount-1:0] out,
    output logic                 out_valid,
    input  logic                 out_ready
);

    logic [dataCount-1:0] r_main_data;
    logic [dataCount-1:0] r_main_data_d;
    logic                 r_main_valid;
    logic                 r_main_valid_d;
    logic [dataCount-1:0] r_skid_data;
    logic [dataCount-1:0] r_skid_data_d;
    logic                 r_skid_valid;
    logic                 r_skid_valid_d;

    logic [dataCount-1:0] w_sel_data;
    logic                 w_accept;
    logic                 w_drain;
    logic                 w_main_open;

    // in_ready comes straight from a flop, so out_ready never reaches it combinationally.
    assign in_ready    = ~r_skid_valid;
    assign out         = r_main_data;
    assign out_valid   = r_main_valid;

    assign w_sel_data  = sel ? in2 : in1;
    assign w_accept    = in_valid & ~r_skid_valid;
    assign w_drain     = r_main_valid & out_ready;
    assign w_main_open = ~r_main_valid | w_drain;

    always_comb begin
        r_main_data_d  = r_main_data;
        r_main_valid_d = r_main_valid;
        r_skid_data_d  = r_skid_data;
        r_skid_valid_d = r_skid_valid;

        if (r_skid_valid) begin
            // Skid full blocks intake; a drain promotes the skid beat into main.
            if (w_drain) begin
                r_main_data_d  = r_skid_data;
                r_main_valid_d = 1'b1;
                r_skid_valid_d = 1'b0;
            end
        end else if (w_accept) begin
            if (w_main_open) begin
                r_main_data_d  = w_sel_data;
                r_main_valid_d = 1'b1;
            end else begin
                r_skid_data_d  = w_sel_data;
                r_skid_valid_d = 1'b1;
            end
        end else if (w_drain) begin
            r_main_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_data  <= '0;
            r_main_valid <= 1'b0;
            r_skid_data  <= '0;
            r_skid_valid <= 1'b0;
        end else begin
            r_main_data  <= r_main_data_d;
            r_main_valid <= r_main_valid_d;
            r_skid_data  <= r_skid_data_d;
            r_skid_valid <= r_skid_valid_d;
        end
    end

endmodule

// File: tb/tb_mux2_pipe.sv
// Scoreboarded bench for mux2_pipe: a 16-bit instance and a 1-bit instance.
module tb_mux2_pipe;

    logic        clk;
    logic        rst_n;
    logic        sel;
    logic [15:0] in1;
    logic [15:0] in2;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out;
    logic        out_valid;
    logic        out_ready;

    logic        b_sel;
    logic [0:0]  b_in1;
    logic [0:0]  b_in2;
    logic        b_in_valid;
    logic        b_in_ready;
    logic [0:0]  b_out;
    logic        b_out_valid;
    logic        b_out_ready;

    int n_vec;
    int n_err;

    logic [15:0] exp_q[$];
    logic [0:0]  b_exp_q[$];

    mux2_pipe #(.dataCount(16)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sel       (sel),
        .in1       (in1),
        .in2       (in2),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    mux2_pipe #(.dataCount(1)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .sel       (b_sel),
        .in1       (b_in1),
        .in2       (b_in2),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .out       (b_out),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitors: a beat leaves at the next rising edge whenever valid & ready hold mid-cycle.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("w16 unexpected beat", {16'h0, out}, 32'hdead);
            end else begin
                chk("w16 scoreboard out", {16'h0, out}, {16'h0, exp_q.pop_front()});
            end
        end
        if (rst_n && b_out_valid && b_out_ready) begin
            if (b_exp_q.size() == 0) begin
                chk("w1 unexpected beat", {31'h0, b_out}, 32'hdead);
            end else begin
                chk("w1 scoreboard out", {31'h0, b_out}, {31'h0, b_exp_q.pop_front()});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        n_vec       = 0;
        n_err       = 0;
        rst_n       = 1'b0;
        sel         = 1'b0;
        in1         = '0;
        in2         = '0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        b_sel       = 1'b0;
        b_in1       = 1'b0;
        b_in2       = 1'b1;
        b_in_valid  = 1'b0;
        b_out_ready = 1'b0;

        tick();
        tick();
        chk("reset out", {16'h0, out}, 32'h0);
        chk("reset out_valid", {31'h0, out_valid}, 32'h0);
        chk("reset in_ready", {31'h0, in_ready}, 32'h1);
        chk("reset w1 in_ready", {31'h0, b_in_ready}, 32'h1);
        rst_n = 1'b1;
        tick();

        // Single beat, sel=0 selects in1.
        in1 = 16'h0001; in2 = 16'h0002; sel = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        exp_q.push_back(16'h0001);
        tick();
        in_valid = 1'b0;
        chk("sel0 out_valid", {31'h0, out_valid}, 32'h1);
        chk("sel0 out", {16'h0, out}, 32'h1);
        tick();
        chk("sel0 drained out_valid", {31'h0, out_valid}, 32'h0);
        chk("sel0 out held", {16'h0, out}, 32'h1);

        // Single beat, sel=1 selects in2.
        sel = 1'b1; in_valid = 1'b1;
        exp_q.push_back(16'h0002);
        tick();
        in_valid = 1'b0;
        chk("sel1 out_valid", {31'h0, out_valid}, 32'h1);
        chk("sel1 out", {16'h0, out}, 32'h2);
        tick();

        // Full-throughput stream with alternating sel.
        in1 = 16'h00AA; in2 = 16'h0055;
        for (int i = 0; i < 4; i++) begin
            sel = i[0];
            in_valid = 1'b1;
            chk("stream in_ready", {31'h0, in_ready}, 32'h1);
            exp_q.push_back(i[0] ? 16'h0055 : 16'h00AA);
            tick();
            chk("stream out", {16'h0, out}, i[0] ? 32'h55 : 32'hAA);
            chk("stream out_valid", {31'h0, out_valid}, 32'h1);
        end
        in_valid = 1'b0;
        tick();
        chk("stream end out_valid", {31'h0, out_valid}, 32'h0);

        // Backpressure: A lands in main, B in skid.
        out_ready = 1'b0;
        in1 = 16'h0001; sel = 1'b0; in_valid = 1'b1;
        exp_q.push_back(16'h0001);
        tick();
        chk("bp A out", {16'h0, out}, 32'h1);
        chk("bp A in_ready", {31'h0, in_ready}, 32'h1);
        in1 = 16'h0002;
        exp_q.push_back(16'h0002);
        tick();
        in_valid = 1'b0;
        chk("bp B in_ready", {31'h0, in_ready}, 32'h0);
        chk("bp B out stable", {16'h0, out}, 32'h1);
        in1 = 16'h0077; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("bp blocked out stable", {16'h0, out}, 32'h1);
        chk("bp blocked in_ready", {31'h0, in_ready}, 32'h0);
        out_ready = 1'b1;
        tick();
        chk("bp release out", {16'h0, out}, 32'h2);
        chk("bp release in_ready", {31'h0, in_ready}, 32'h1);
        tick();
        chk("bp done out_valid", {31'h0, out_valid}, 32'h0);

        // Fill main and skid, then reset mid-cycle; those beats must never emerge.
        out_ready = 1'b0;
        in1 = 16'h0033; sel = 1'b0; in_valid = 1'b1;
        tick();
        in1 = 16'h0044;
        tick();
        in_valid = 1'b0;
        chk("pre-reset in_ready", {31'h0, in_ready}, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset out_valid", {31'h0, out_valid}, 32'h0);
        chk("async reset out", {16'h0, out}, 32'h0);
        chk("async reset in_ready", {31'h0, in_ready}, 32'h1);
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post-reset no stale", {31'h0, out_valid}, 32'h0);
        end

        // 1-bit instance: out follows sel one cycle after each accept.
        b_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            b_sel = ~i[0];
            b_in_valid = 1'b1;
            b_exp_q.push_back(~i[0]);
            tick();
            chk("w1 out", {31'h0, b_out}, {31'h0, ~i[0]});
            chk("w1 out_valid", {31'h0, b_out_valid}, 32'h1);
        end
        b_in_valid = 1'b0;
        tick();
        tick();

        chk("w16 queue empty", exp_q.size(), 32'h0);
        chk("w1 queue empty", b_exp_q.size(), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
